// File: rtl/echo_request_dispatch_pkg.sv
// Shared message layout and decode constants for the Echo request path.
// Imported by the FIFO, the handshake interface and echo_request_dispatch.
package echo_pkg;

    localparam int ECHO_MSG_W = 96;
    localparam int ECHO_HDR_W = 16;

    localparam logic [ECHO_HDR_W-1:0] ECHO_METH_SAY = 16'h0000;
    localparam logic [ECHO_HDR_W-1:0] ECHO_SAY_LEN  = 16'd2;

    // Header field offsets inside the flat 96-bit message
    localparam int ECHO_HDR_LEN_LSB = 0;
    localparam int ECHO_HDR_ID_LSB  = 16;

    // Declared MSB first so it overlays the flat message bit-for-bit
    typedef struct packed {
        logic [31:0]           v;
        logic [31:0]           meth;
        logic [ECHO_HDR_W-1:0] hdr_id;
        logic [ECHO_HDR_W-1:0] hdr_len;
    } echo_msg_t;

    function automatic logic echo_is_say(input logic [ECHO_MSG_W-1:0] msg);
        return (msg[ECHO_HDR_ID_LSB +: ECHO_HDR_W] == ECHO_METH_SAY) &&
               (msg[ECHO_HDR_LEN_LSB +: ECHO_HDR_W] == ECHO_SAY_LEN);
    endfunction

endpackage

// File: rtl/echo_request_dispatch_if.sv
// Request-side and core-side handshake signals of echo_request_dispatch.
// Modport slave is the dispatcher's view; master is the surrounding system.
interface echo_request_dispatch_if;
    import echo_pkg::*;

    // Handshake: a transfer happens on a rising edge where the strobe (__ENA)
    // is high; a strobe may only be raised while the matching __RDY is high.
    // __RDY never depends on the same-cycle __ENA of its partner.
    logic                  enq__ENA;
    logic [ECHO_MSG_W-1:0] enq_v;
    logic                  enq__RDY;
    logic                  say__ENA;
    logic [31:0]           say_meth;
    logic [31:0]           say_v;
    logic                  say__RDY;
    logic                  rule_enable;
    logic                  rule_ready;

    modport master (
        output enq__ENA,
        output enq_v,
        output say__RDY,
        output rule_enable,
        input  enq__RDY,
        input  say__ENA,
        input  say_meth,
        input  say_v,
        input  rule_ready
    );

    modport slave (
        input  enq__ENA,
        input  enq_v,
        input  say__RDY,
        input  rule_enable,
        output enq__RDY,
        output say__ENA,
        output say_meth,
        output say_v,
        output rule_ready
    );

endinterface

// File: rtl/echo_request_dispatch_msg_fifo.sv
// echo_msg_fifo: generic circular-buffer FIFO, W bits wide, DEPTH entries.
// Pointers carry one extra wrap bit; push when full and pop when empty are ignored.
module echo_msg_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data_in,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    always_comb begin
        full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        empty   = (wr_ptr == rd_ptr);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is cleared too so a flushed queue never exposes stale payloads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

endmodule

// File: rtl/echo_request_dispatch.sv
// Queues portal request messages and dispatches well-formed `say` calls to the core.
// Optional statistics counters are built when ECHO_REQUEST_DISPATCH_STATS_EN is defined.
module echo_request_dispatch
    import echo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic CLK,
    input  logic nRST,
    echo_request_dispatch_if.slave bus
`ifdef ECHO_REQUEST_DISPATCH_STATS_EN
    ,
    output logic [15:0] drop_count,
    output logic [15:0] say_count
`endif
);

    echo_msg_t head;
    logic      full;
    logic      empty;
    logic      head_good;
    logic      fire;

    echo_msg_fifo #(
        .W     (ECHO_MSG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (nRST),
        .push    (bus.enq__ENA),
        .pop     (fire),
        .data_in (bus.enq_v),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    // A bad head is dropped regardless of say__RDY; a good one waits for the core
    always_comb begin
        head_good      = 1'b0;
        fire           = 1'b0;
        bus.enq__RDY   = !full;
        bus.rule_ready = 1'b0;
        bus.say__ENA   = 1'b0;
        bus.say_meth   = '0;
        bus.say_v      = '0;

        head_good      = echo_is_say(head);
        bus.rule_ready = !empty && (!head_good || bus.say__RDY);
        fire           = bus.rule_enable && bus.rule_ready;
        if (fire && head_good) begin
            bus.say__ENA = 1'b1;
            bus.say_meth = head.meth;
            bus.say_v    = head.v;
        end
    end

`ifdef ECHO_REQUEST_DISPATCH_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            drop_count <= '0;
            say_count  <= '0;
        end else if (fire) begin
            if (head_good) begin
                say_count <= say_count + 16'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_echo_request_dispatch.sv
// Directed plus randomized bench for echo_request_dispatch against a queue-based model.
// Counter checks are compiled in when ECHO_REQUEST_DISPATCH_STATS_EN is defined.
module tb_echo_request_dispatch;
    import echo_pkg::*;

    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    echo_request_dispatch_if bus ();

`ifdef ECHO_REQUEST_DISPATCH_STATS_EN
    logic [15:0] drop_count;
    logic [15:0] say_count;
`endif

    echo_request_dispatch #(.DEPTH(DEPTH)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
`ifdef ECHO_REQUEST_DISPATCH_STATS_EN
        ,
        .drop_count (drop_count),
        .say_count  (say_count)
`endif
    );

    // ---------------- scoreboard ----------------
    int          tests  = 0;
    int          failed = 0;
    logic [95:0] exp_q[$];
    logic [15:0] exp_drop = 16'd0;
    logic [15:0] exp_say  = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [95:0] mk(input logic [15:0] id, input logic [15:0] len,
                                       input logic [31:0] meth, input logic [31:0] v);
        return {v, meth, id, len};
    endfunction

    // ---------------- driver + model step ----------------
    task automatic step(input logic en, input logic [95:0] msg,
                        input logic srdy, input logic ren);
        int          occ;
        logic        is_full;
        logic        good;
        logic        rr;
        logic        fire;
        logic [95:0] hd;
        @(negedge clk);
        bus.enq__ENA    = en;
        bus.enq_v       = msg;
        bus.say__RDY    = srdy;
        bus.rule_enable = ren;
        #1;
        occ     = exp_q.size();
        is_full = (occ == DEPTH);
        hd      = (occ > 0) ? exp_q[0] : '0;
        good    = (occ > 0) && (hd[31:16] == 16'h0000) && (hd[15:0] == 16'd2);
        rr      = (occ > 0) && (!good || srdy);
        fire    = ren && rr;
        chk("enq_rdy", {31'd0, bus.enq__RDY}, {31'd0, !is_full});
        chk("rule_ready", {31'd0, bus.rule_ready}, {31'd0, rr});
        chk("say_ena", {31'd0, bus.say__ENA}, {31'd0, fire && good});
        if (!fire || good) begin
            chk("say_meth", bus.say_meth, (fire && good) ? hd[63:32] : 32'd0);
            chk("say_v", bus.say_v, (fire && good) ? hd[95:64] : 32'd0);
        end
`ifdef ECHO_REQUEST_DISPATCH_STATS_EN
        chk("drop_count", {16'd0, drop_count}, {16'd0, exp_drop});
        chk("say_count", {16'd0, say_count}, {16'd0, exp_say});
`endif
        @(posedge clk);
        if (fire) begin
            void'(exp_q.pop_front());
            if (good) exp_say = exp_say + 16'd1;
            else if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
        end
        if (en && !is_full) exp_q.push_back(msg);
    endtask

    task automatic idle(input int n, input logic srdy, input logic ren);
        for (int i = 0; i < n; i++) step(1'b0, '0, srdy, ren);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        en;
        logic [95:0] msg;
        bus.enq__ENA    = 1'b0;
        bus.enq_v       = '0;
        bus.say__RDY    = 1'b0;
        bus.rule_enable = 1'b0;

        // reset values
        #2;
        chk("rst_enq_rdy", {31'd0, bus.enq__RDY}, 32'd1);
        chk("rst_say_ena", {31'd0, bus.say__ENA}, 32'd0);
        chk("rst_say_meth", bus.say_meth, 32'd0);
        chk("rst_say_v", bus.say_v, 32'd0);
        chk("rst_rule_ready", {31'd0, bus.rule_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single good message dispatches the next cycle
        step(1'b1, mk(16'h0, 16'd2, 32'h5, 32'h1234), 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        idle(1, 1'b1, 1'b1);

        // fill with say__RDY low, then release and drain in order
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, mk(16'h0, 16'd2, 32'h100 + i, 32'hA0 + i), 1'b0, 1'b1);
        idle(2, 1'b0, 1'b1);
        // push while full must be ignored
        step(1'b1, mk(16'h0, 16'd2, 32'hDEAD, 32'hBEEF), 1'b0, 1'b1);
        idle(DEPTH + 2, 1'b1, 1'b1);

        // bad head dropped even with say__RDY low; good one waits
        step(1'b1, mk(16'h3, 16'd2, 32'h77, 32'h88), 1'b0, 1'b1);
        step(1'b1, mk(16'h0, 16'd2, 32'h9, 32'h99), 1'b0, 1'b1);
        idle(3, 1'b0, 1'b1);
        idle(2, 1'b1, 1'b1);

        // rule_enable low holds everything
        step(1'b1, mk(16'h0, 16'd2, 32'h11, 32'h22), 1'b1, 1'b0);
        idle(2, 1'b1, 1'b0);
        idle(1, 1'b1, 1'b1);

        // simultaneous push/pop at occupancy 1, pointers wrap
        step(1'b1, mk(16'h0, 16'd2, 32'h1, 32'd0), 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++)
            step(1'b1, mk(16'h0, 16'd2, 32'h1, i), 1'b1, 1'b1);
        idle(2, 1'b1, 1'b1);

        // asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++)
            step(1'b1, mk(16'h0, 16'd2, 32'h300 + i, 32'h30 + i), 1'b0, 1'b1);
        @(negedge clk);
        bus.enq__ENA    = 1'b0;
        bus.say__RDY    = 1'b1;
        bus.rule_enable = 1'b1;
        rst_n           = 1'b0;
        #1;
        chk("mid_rst_enq_rdy", {31'd0, bus.enq__RDY}, 32'd1);
        chk("mid_rst_rule_ready", {31'd0, bus.rule_ready}, 32'd0);
        chk("mid_rst_say_ena", {31'd0, bus.say__ENA}, 32'd0);
`ifdef ECHO_REQUEST_DISPATCH_STATS_EN
        chk("mid_rst_drop", {16'd0, drop_count}, 32'd0);
        chk("mid_rst_say", {16'd0, say_count}, 32'd0);
`endif
        exp_q.delete();
        exp_drop = 16'd0;
        exp_say  = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3, 1'b1, 1'b1);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            en = (exp_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) != 0)
                msg = mk(16'h0, 16'd2, $urandom, $urandom);
            else
                msg = mk(16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)), $urandom, $urandom);
            step(en, msg, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
        end
        idle(DEPTH + 2, 1'b1, 1'b1);

`ifdef ECHO_REQUEST_DISPATCH_STATS_EN
        // drop counter saturation
        for (int i = 0; i < 70000; i++)
            step(1'b1, mk(16'h3, 16'd2, 32'd0, i), 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);
        chk("drop_saturated", {16'd0, drop_count}, 32'h0000FFFF);
`endif

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/echo_request_dispatch.md
# echo_request_dispatch

Buffers 96-bit request messages arriving from the portal pipe and dispatches them as `say` method calls into the Echo core. It sits between the request pipe output (`pipe$enq`) and the core's `say` method, replacing a direct wire with a DEPTH-entry queue plus header decode. Malformed or unknown messages are discarded so the core never sees them.

## Interface
- DEPTH, 4: message queue entries; power of two, at least 2.
- CLK  input  1  clock; all state changes on the rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- enq__ENA  input  1  upstream enqueue strobe; asserted only while enq__RDY is high.
- enq_v  input  96  message: [31:16] method id, [15:0] length in words, [63:32] meth, [95:64] v.
- enq__RDY  output  1  queue not full.
- say__ENA  output  1  call strobe to the core's `say`.
- say_meth  output  32  `meth` argument; valid while say__ENA is high.
- say_v  output  32  `v` argument; valid while say__ENA is high.
- say__RDY  input  1  core can accept `say`.
- rule_enable  input  1  scheduler enable for the dispatch rule.
- rule_ready  output  1  dispatch rule can fire.
- drop_count  output  16  discarded messages, saturating. Present only with the stats macro.
- say_count  output  16  dispatched calls, wrapping. Present only with the stats macro.

## Operation
- Queue: circular buffer with read and write pointers of log2(DEPTH)+1 bits; MSB used for wrap. Full when the index bits are equal and the MSBs differ. Empty when the pointers are equal.
- Enqueue: on a rising edge with enq__ENA high, enq_v is written at the write pointer and the write pointer increments. enq__ENA while full is a protocol violation; the message is ignored and the queue is not corrupted.
- Head decode (combinational on the head entry): the head is `good` when method id == 16'h0000 and length == 16'd2. Any other head is `bad`.
- rule_ready = !empty && (bad || say__RDY).
- Dispatch fires when rule_enable && rule_ready.
  - If the head is good: say__ENA = 1, say_meth = head[63:32], say_v = head[95:64]. Pop the head; say_count increments.
  - If the head is bad: say__ENA stays 0. Pop the head; drop_count increments and holds at 16'hFFFF.
- When dispatch does not fire, say__ENA = 0 and say_meth and say_v are driven to 0.
- At most one pop and one push per cycle.

## Timing
- Reset values: enq__RDY = 1, say__ENA = 0, say_meth = 0, say_v = 0, rule_ready = 0, both counters = 0. Pointers reset to 0.
- Reset asserted mid-operation flushes the queue immediately; in-flight messages are lost.
- Latency: a message enqueued in cycle N can dispatch in cycle N+1 at the earliest. There is no same-cycle bypass.
- enq__RDY depends only on the current occupancy, never on a same-cycle pop. When the queue is full, upstream waits one cycle even if a pop is occurring.
- Push and pop in the same cycle are allowed, including at occupancy 1; occupancy is then unchanged.
- say__RDY low with a good head holds the message: rule_ready = 0 and the head is not popped.
- say__RDY low with a bad head does not block the drop.
- Pointer wrap at DEPTH entries is seamless; ordering is strictly FIFO.

## Configuration
- ECHO_REQUEST_DISPATCH_STATS_EN defined: the drop_count and say_count ports and their registers exist, with the behaviour above.
- Macro undefined: both ports and registers are absent. Drops are silent; all other behaviour is identical.

## Structure
- Shared package echo_pkg holds:
  - ECHO_MSG_W = 96
  - ECHO_METH_SAY = 16'h0000
  - ECHO_SAY_LEN = 16'd2
  - header field offsets
  - a packed struct for the message layout (hdr id, hdr len, meth, v)
- Sub-module echo_msg_fifo: a generic width/depth FIFO with push, pop, full, empty and head outputs, and the same reset behaviour. echo_request_dispatch instantiates it and adds the decode, dispatch and counter logic.

## Test plan
- Reset, then push {v=32'h1234, meth=32'h5, id=0, len=2} with say__RDY=1 and rule_enable=1 → next cycle say__ENA=1, say_meth=5, say_v=32'h1234; say_count=1.
- Hold say__RDY=0 and push 4 good messages (DEPTH=4) → enq__RDY=0 after the 4th. Release say__RDY → 4 dispatches in order on consecutive cycles; enq__RDY returns to 1 the cycle after the first pop.
- Push id=16'h0003, len=2, then a good message, with say__RDY=0 → the bad message is dropped (drop_count=1, say__ENA never high for it); the good message waits for say__RDY.
- Simultaneous push and pop at occupancy 1 for 10 cycles with incrementing v → occupancy stays 1, outputs are in order, pointers wrap twice with no loss.
- Assert nRST low with 3 entries queued → immediately enq__RDY=1, rule_ready=0, say__ENA=0, counters 0; after release, no stale dispatch.
- With the stats macro: 70000 bad messages → drop_count saturates at 16'hFFFF.
